traffic_light_monitor: RTL and testbench

Receive-side checker for the two-direction traffic-light lamp bus. It samples the east-west and south-north `rgyl` lamp vectors driven by the traffic-light controller and decodes them into a combined phase. It measures the duration of each phase in clock cycles and raises sticky flags for conflicting greens, malformed lamp codes, illegal phase sequences and stuck phases. It sits beside the controller in the intersection subsystem and feeds the status/debug register block.

---
 rtl/traffic_light_monitor.sv | 193 +++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Receive-side checker for the two-direction traffic-light lamp bus.
// The EW and SN lamp vectors are registered every cycle. Each sampled pair is
// decoded into a combined phase. The block measures how many samples each
// phase lasts and keeps sticky flags for lamp faults and sequencing faults.
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous, active-high reset
//   light_ew_rgyl  : EW lamps, [3]=red [2]=green [1]=yellow [0]=left-turn
//   light_sn_rgyl  : SN lamps, same bit order
//   clr_err        : synchronous clear of the four sticky error flags
//   phase          : decoded phase (0 ALL_RED .. 6 SN_L, 7 ILLEGAL)
//   phase_valid    : one-cycle pulse whenever phase changes
//   last_len       : sample count of the phase that just ended (saturating)
//   phase_count    : number of phase changes, wraps modulo 2^16
//   err_conflict   : sticky, both directions non-red in one sample
//   err_code       : sticky, a lamp vector was not exactly one-hot
//   err_seq        : sticky, illegal phase transition
//   err_timeout    : sticky, a phase lasted MAX_CYCLES samples
module traffic_light_monitor #(
  parameter int CNT_W      = 8,
  parameter int MAX_CYCLES = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       light_ew_rgyl,
  input  logic [3:0]       light_sn_rgyl,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] last_len,
  output logic [15:0]      phase_count,
  output logic             err_conflict,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    EW_G    = 3'd1,
    EW_Y    = 3'd2,
    EW_L    = 3'd3,
    SN_G    = 3'd4,
    SN_Y    = 3'd5,
    SN_L    = 3'd6,
    ILLEGAL = 3'd7
  } phase_e;

  logic [3:0]       ewQ, snQ;
  logic             sampleValidQ;
  logic             firstQ, firstD;
  phase_e           phaseQ, phaseD;
  logic             validQ, validD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [CNT_W-1:0] lastLenQ, lastLenD;
  logic [15:0]      countQ, countD;
  logic             errConflictQ, errConflictD;
  logic             errCodeQ, errCodeD;
  logic             errSeqQ, errSeqD;
  logic             errTimeoutQ, errTimeoutD;

  logic   codeBad, conflict, ewRed, snRed;
  logic   hitSeq, hitTimeout;
  phase_e decoded;

  // Returns 1 when moving from one phase to a different one is allowed.
  // Anything into or out of ILLEGAL falls through to the default.
  function automatic logic legalMove(input phase_e from, input phase_e to);
    logic ok;
    ok = 1'b0;
    case (from)
      ALL_RED: ok = (to == EW_G) || (to == EW_L) || (to == SN_G) || (to == SN_L);
      EW_G:    ok = (to == EW_L) || (to == EW_Y);
      EW_L:    ok = (to == EW_Y);
      EW_Y:    ok = (to == ALL_RED) || (to == SN_G) || (to == SN_L);
      SN_G:    ok = (to == SN_L) || (to == SN_Y);
      SN_L:    ok = (to == SN_Y);
      SN_Y:    ok = (to == ALL_RED) || (to == EW_G) || (to == EW_L);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Decode of the sampled lamp pair. A lamp-code fault masks the conflict
  // check, so at most one of the two fault flags is raised per sample.
  // Once both vectors are one-hot, a direction is red exactly when bit 3 is set.
  always_comb begin
    codeBad  = !$onehot(ewQ) || !$onehot(snQ);
    ewRed    = ewQ[3];
    snRed    = snQ[3];
    conflict = !codeBad && !ewRed && !snRed;
    decoded  = ALL_RED;
    if (codeBad || conflict) begin
      decoded = ILLEGAL;
    end else if (ewRed && snRed) begin
      decoded = ALL_RED;
    end else if (!ewRed) begin
      case (ewQ)
        4'b0100: decoded = EW_G;
        4'b0010: decoded = EW_Y;
        default: decoded = EW_L;
      endcase
    end else begin
      case (snQ)
        4'b0100: decoded = SN_G;
        4'b0010: decoded = SN_Y;
        default: decoded = SN_L;
      endcase
    end
  end

  // Phase tracking, length counting and error flag next-state.
  // The first decoded sample after reset only loads the phase and counter.
  // A flag raised in the same cycle as clr_err stays set.
  always_comb begin
    firstD     = firstQ;
    phaseD     = phaseQ;
    validD     = 1'b0;
    cntD       = cntQ;
    lastLenD   = lastLenQ;
    countD     = countQ;
    hitSeq     = 1'b0;
    hitTimeout = 1'b0;
    if (sampleValidQ) begin
      if (firstQ) begin
        firstD = 1'b0;
        phaseD = decoded;
        cntD   = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (decoded != phaseQ) begin
        phaseD   = decoded;
        validD   = 1'b1;
        lastLenD = cntQ;
        cntD     = {{(CNT_W-1){1'b0}}, 1'b1};
        countD   = countQ + 16'd1;
        hitSeq   = !legalMove(phaseQ, decoded);
      end else if (cntQ != {CNT_W{1'b1}}) begin
        cntD = cntQ + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      hitTimeout = (cntD == CNT_W'(MAX_CYCLES));
    end
    errConflictD = (errConflictQ && !clr_err) || (sampleValidQ && conflict);
    errCodeD     = (errCodeQ && !clr_err) || (sampleValidQ && codeBad);
    errSeqD      = (errSeqQ && !clr_err) || hitSeq;
    errTimeoutD  = (errTimeoutQ && !clr_err) || hitTimeout;
  end

  // All state, including the lamp sample stage, in one register block.
  // sampleValidQ keeps the reset-cleared sample registers from being decoded
  // as a lamp-code fault on the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ewQ          <= 4'd0;
      snQ          <= 4'd0;
      sampleValidQ <= 1'b0;
      firstQ       <= 1'b1;
      phaseQ       <= ALL_RED;
      validQ       <= 1'b0;
      cntQ         <= '0;
      lastLenQ     <= '0;
      countQ       <= 16'd0;
      errConflictQ <= 1'b0;
      errCodeQ     <= 1'b0;
      errSeqQ      <= 1'b0;
      errTimeoutQ  <= 1'b0;
    end else begin
      ewQ          <= light_ew_rgyl;
      snQ          <= light_sn_rgyl;
      sampleValidQ <= 1'b1;
      firstQ       <= firstD;
      phaseQ       <= phaseD;
      validQ       <= validD;
      cntQ         <= cntD;
      lastLenQ     <= lastLenD;
      countQ       <= countD;
      errConflictQ <= errConflictD;
      errCodeQ     <= errCodeD;
      errSeqQ      <= errSeqD;
      errTimeoutQ  <= errTimeoutD;
    end
  end

  assign phase        = phaseQ;
  assign phase_valid  = validQ;
  assign last_len     = lastLenQ;
  assign phase_count  = countQ;
  assign err_conflict = errConflictQ;
  assign err_code     = errCodeQ;
  assign err_seq      = errSeqQ;
  assign err_timeout  = errTimeoutQ;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
// Directed bench for traffic_light_monitor. Each expected phase change is
// pushed into a queue before its lamps are driven. A monitor pops the queue on
// every phase_valid pulse and compares phase, last_len and phase_count.
// Sticky flags and reset behaviour are checked inline at chosen points.
module tb_traffic_light_monitor;

  localparam logic [3:0] RED = 4'b1000;
  localparam logic [3:0] GRN = 4'b0100;
  localparam logic [3:0] YEL = 4'b0010;
  localparam logic [3:0] LFT = 4'b0001;

  logic        clk;
  logic        reset;
  logic [3:0]  light_ew_rgyl;
  logic [3:0]  light_sn_rgyl;
  logic        clr_err;
  logic [2:0]  phase;
  logic        phase_valid;
  logic [7:0]  last_len;
  logic [15:0] phase_count;
  logic        err_conflict;
  logic        err_code;
  logic        err_seq;
  logic        err_timeout;

  typedef struct {
    logic [2:0]  ph;
    logic [7:0]  len;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  int          checks;
  int          errors;
  logic [15:0] expCount;

  traffic_light_monitor #(.CNT_W(8), .MAX_CYCLES(200)) dut (
    .clk           (clk),
    .reset         (reset),
    .light_ew_rgyl (light_ew_rgyl),
    .light_sn_rgyl (light_sn_rgyl),
    .clr_err       (clr_err),
    .phase         (phase),
    .phase_valid   (phase_valid),
    .last_len      (last_len),
    .phase_count   (phase_count),
    .err_conflict  (err_conflict),
    .err_code      (err_code),
    .err_seq       (err_seq),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a lamp pair for n samples; returns on a falling edge.
  task automatic applyStimulus(input logic [3:0] ew, input logic [3:0] sn, input int n);
    light_ew_rgyl = ew;
    light_sn_rgyl = sn;
    repeat (n) @(negedge clk);
  endtask

  task automatic expectChange(input logic [2:0] ph, input logic [7:0] len);
    exp_t e;
    expCount = expCount + 16'd1;
    e.ph  = ph;
    e.len = len;
    e.cnt = expCount;
    expQ.push_back(e);
  endtask

  // One-cycle clr_err pulse followed by one more sample.
  task automatic pulseClear();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkErrors(input int c, input int k, input int s, input int t);
    checkOutput("err_conflict", int'(err_conflict), c);
    checkOutput("err_code", int'(err_code), k);
    checkOutput("err_seq", int'(err_seq), s);
    checkOutput("err_timeout", int'(err_timeout), t);
  endtask

  // Scoreboard monitor: every phase_valid pulse must match the queue head.
  always @(negedge clk) begin
    if (!reset && phase_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected phase_valid", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("pv phase", int'(phase), int'(e.ph));
        checkOutput("pv last_len", int'(last_len), int'(e.len));
        checkOutput("pv phase_count", int'(phase_count), int'(e.cnt));
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    expCount      = 16'd0;
    reset         = 1'b1;
    clr_err       = 1'b0;
    light_ew_rgyl = 4'd0;
    light_sn_rgyl = 4'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset phase", int'(phase), 0);
    checkOutput("reset phase_valid", int'(phase_valid), 0);
    checkOutput("reset last_len", int'(last_len), 0);
    checkOutput("reset phase_count", int'(phase_count), 0);
    checkErrors(0, 0, 0, 0);
    reset = 1'b0;

    $display("[TB] full EW/SN cycle");
    applyStimulus(GRN, RED, 10);
    expectChange(3'd2, 8'd10);
    applyStimulus(YEL, RED, 3);
    expectChange(3'd0, 8'd3);
    applyStimulus(RED, RED, 2);
    expectChange(3'd4, 8'd2);
    applyStimulus(RED, GRN, 10);
    expectChange(3'd5, 8'd10);
    applyStimulus(RED, YEL, 3);
    expectChange(3'd0, 8'd3);
    applyStimulus(RED, RED, 6);
    checkOutput("cycle phase", int'(phase), 0);
    checkOutput("cycle phase_count", int'(phase_count), 5);
    checkErrors(0, 0, 0, 0);

    $display("[TB] conflicting greens");
    expectChange(3'd7, 8'd6);
    applyStimulus(GRN, GRN, 1);
    expectChange(3'd1, 8'd1);
    applyStimulus(GRN, RED, 4);
    checkOutput("after conflict phase", int'(phase), 1);
    checkErrors(1, 0, 1, 0);
    pulseClear();
    checkErrors(0, 0, 0, 0);

    $display("[TB] malformed lamp code and skipped yellow");
    expectChange(3'd7, 8'd6);
    applyStimulus(4'b1100, RED, 1);
    expectChange(3'd1, 8'd1);
    applyStimulus(GRN, RED, 3);
    checkErrors(0, 1, 1, 0);
    pulseClear();
    checkErrors(0, 0, 0, 0);
    expectChange(3'd0, 8'd5);
    applyStimulus(RED, RED, 3);
    checkErrors(0, 0, 1, 0);
    pulseClear();
    checkErrors(0, 0, 0, 0);

    $display("[TB] stuck phase timeout and counter saturation");
    expectChange(3'd4, 8'd5);
    applyStimulus(RED, GRN, 199);
    checkOutput("timeout at 198", int'(err_timeout), 0);
    @(negedge clk);
    checkOutput("timeout at 199", int'(err_timeout), 0);
    @(negedge clk);
    checkOutput("timeout at 200", int'(err_timeout), 1);
    applyStimulus(RED, GRN, 99);
    expectChange(3'd5, 8'd255);
    applyStimulus(RED, YEL, 3);
    checkErrors(0, 0, 0, 1);
    expectChange(3'd0, 8'd3);
    applyStimulus(RED, RED, 4);
    expectChange(3'd1, 8'd4);
    applyStimulus(GRN, RED, 5);
    checkOutput("queue drained before reset", expQ.size(), 0);

    $display("[TB] reset mid-phase");
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset phase", int'(phase), 0);
    checkOutput("async reset phase_count", int'(phase_count), 0);
    checkOutput("async reset last_len", int'(last_len), 0);
    checkErrors(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    expCount = 16'd0;
    applyStimulus(GRN, RED, 4);
    checkOutput("first sample phase", int'(phase), 1);
    checkOutput("first sample phase_count", int'(phase_count), 0);
    checkOutput("first sample last_len", int'(last_len), 0);
    checkErrors(0, 0, 0, 0);

    $display("[TB] back-to-back changes");
    expectChange(3'd2, 8'd4);
    applyStimulus(YEL, RED, 1);
    expectChange(3'd0, 8'd1);
    applyStimulus(RED, RED, 1);
    expectChange(3'd6, 8'd1);
    applyStimulus(RED, LFT, 3);
    expectChange(3'd5, 8'd3);
    applyStimulus(RED, YEL, 3);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard empty", expQ.size(), 0);
    checkOutput("final phase", int'(phase), 5);
    checkOutput("final phase_count", int'(phase_count), 4);
    checkErrors(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
